// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse letter codes, A-H pattern/length table and receiver FSM states
package morse_pkg;

    typedef enum logic [2:0] {
        LTR_A = 3'd0, LTR_B = 3'd1, LTR_C = 3'd2, LTR_D = 3'd3,
        LTR_E = 3'd4, LTR_F = 3'd5, LTR_G = 3'd6, LTR_H = 3'd7
    } letter_t;

    // pattern bit0 is the first symbol sent; 1 = dash
    localparam logic [3:0] PAT_A = 4'b0010;  localparam logic [2:0] LEN_A = 3'd2;
    localparam logic [3:0] PAT_B = 4'b0001;  localparam logic [2:0] LEN_B = 3'd4;
    localparam logic [3:0] PAT_C = 4'b0101;  localparam logic [2:0] LEN_C = 3'd4;
    localparam logic [3:0] PAT_D = 4'b0001;  localparam logic [2:0] LEN_D = 3'd3;
    localparam logic [3:0] PAT_E = 4'b0000;  localparam logic [2:0] LEN_E = 3'd1;
    localparam logic [3:0] PAT_F = 4'b0100;  localparam logic [2:0] LEN_F = 3'd4;
    localparam logic [3:0] PAT_G = 4'b0011;  localparam logic [2:0] LEN_G = 3'd3;
    localparam logic [3:0] PAT_H = 4'b0000;  localparam logic [2:0] LEN_H = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MARK, ST_SPACE, ST_ABORT, ST_DECODE
    } state_t;

    typedef struct packed {
        logic    hit;
        letter_t code;
    } decode_t;

    function automatic decode_t decode_symbols(input logic [3:0] pattern, input logic [2:0] length);
        decode_t d;
        d.hit  = 1'b1;
        d.code = LTR_A;
        case ({length, pattern})
            {LEN_A, PAT_A}: d.code = LTR_A;
            {LEN_B, PAT_B}: d.code = LTR_B;
            {LEN_C, PAT_C}: d.code = LTR_C;
            {LEN_D, PAT_D}: d.code = LTR_D;
            {LEN_E, PAT_E}: d.code = LTR_E;
            {LEN_F, PAT_F}: d.code = LTR_F;
            {LEN_G, PAT_G}: d.code = LTR_G;
            {LEN_H, PAT_H}: d.code = LTR_H;
            default:        d.hit  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/morse_code_receiver_if.sv
// rtl/morse_code_receiver_if.sv - Morse line input and decoded-letter outputs
interface morse_code_receiver_if;
    logic       key_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_error;
    logic [3:0] pattern;
    logic [2:0] length;

    modport master (output key_in, input letter, letter_valid, letter_error, pattern, length);
    modport slave  (input key_in, output letter, letter_valid, letter_error, pattern, length);
endinterface

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - tick prescaler feeding a saturating 3-bit Morse unit counter
module morse_unit_timer #(
    parameter int TICKS_PER_UNIT = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       tick_enable,
    output logic [2:0] units
);
    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

    logic [TICK_W-1:0] tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick  <= '0;
            units <= '0;
        end else if (clear) begin
            tick  <= '0;
            units <= '0;
        end else if (tick_enable) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                if (units != 3'd7)
                    units <= units + 3'd1;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end
endmodule

// File: rtl/morse_code_receiver.sv
// rtl/morse_code_receiver.sv - Morse A-H letter receiver; MORSE_RX_GLITCH_FILTER_EN adds a 16-cycle input debounce
module morse_code_receiver
    import morse_pkg::*;
#(
    parameter int TICKS_PER_UNIT   = 25000000,
    parameter int DASH_MIN_UNITS   = 2,
    parameter int LETTER_GAP_UNITS = 3
) (
    input logic CLOCK_50,
    input logic reset,
    morse_code_receiver_if.slave bus
);
    localparam logic [2:0] DASH_MIN = 3'(DASH_MIN_UNITS);
    localparam logic [2:0] GAP      = 3'(LETTER_GAP_UNITS);

    logic       key_meta, key_s, key_lvl, key_prev;
    logic       rise, fall;
    logic [2:0] units;
    state_t     state;
    letter_t    letter_q;
    logic [3:0] pattern_q;
    logic [2:0] length_q;
    logic       valid_q, error_q;
    decode_t    dec;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= bus.key_in;
            key_s    <= key_meta;
        end
    end

`ifdef MORSE_RX_GLITCH_FILTER_EN
    logic [3:0] stable_cnt;
    logic       key_f;

    // a new level must persist for 16 consecutive cycles before it is adopted
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            key_f      <= 1'b0;
        end else if (key_s == key_f) begin
            stable_cnt <= '0;
        end else if (stable_cnt == 4'd15) begin
            stable_cnt <= '0;
            key_f      <= key_s;
        end else begin
            stable_cnt <= stable_cnt + 4'd1;
        end
    end
    assign key_lvl = key_f;
`else
    assign key_lvl = key_s;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) key_prev <= 1'b0;
        else       key_prev <= key_lvl;
    end

    assign rise = key_lvl & ~key_prev;
    assign fall = ~key_lvl & key_prev;
    assign dec  = decode_symbols(pattern_q, length_q);

    morse_unit_timer #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_timer (
        .clk        (CLOCK_50),
        .rst        (reset),
        .clear      (rise | fall),
        .tick_enable(state != ST_IDLE),
        .units      (units)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            letter_q  <= LTR_A;
            pattern_q <= '0;
            length_q  <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                ST_IDLE: if (rise) begin
                    pattern_q <= '0;
                    length_q  <= '0;
                    letter_q  <= LTR_A;
                    state     <= ST_MARK;
                end
                ST_MARK: if (fall) begin
                    if (length_q == 3'd4) begin
                        state <= ST_ABORT;
                    end else begin
                        pattern_q[length_q[1:0]] <= (units >= DASH_MIN);
                        length_q <= length_q + 3'd1;
                        state    <= ST_SPACE;
                    end
                end
                // the gap test wins over a coincident rise so the letter is never split
                ST_SPACE: if (units >= GAP) begin
                    valid_q <= dec.hit;
                    error_q <= ~dec.hit;
                    if (dec.hit) letter_q <= dec.code;
                    state <= ST_DECODE;
                end else if (rise) begin
                    state <= ST_MARK;
                end
                ST_ABORT: if (!key_lvl && units >= GAP) begin
                    error_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_DECODE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.letter       = letter_q;
    assign bus.letter_valid = valid_q;
    assign bus.letter_error = error_q;
    assign bus.pattern      = pattern_q;
    assign bus.length       = length_q;
endmodule

// File: tb/tb_morse_code_receiver.sv
// tb/tb_morse_code_receiver.sv - randomized self-checking bench against a Morse-string reference model
module tb_morse_code_receiver;
    localparam int T        = 4;
    localparam int GAP      = 3;
    localparam int LAT      = 2 + GAP * T + 2;
    localparam int WINDOW   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_code_receiver_if bus();

    morse_code_receiver #(.TICKS_PER_UNIT(T)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nv       = 0;
    int ne       = 0;
    int last_pulse = -1;
    string morse_tbl [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.letter_valid) nv++;
        if (bus.letter_error) ne++;
        if (bus.letter_valid || bus.letter_error) begin
            last_pulse = cyc;
            check_eq("pulse_exclusive", int'(bus.letter_valid & bus.letter_error), 0);
        end
    end

    task automatic play(input string code, input bit rnd);
        for (int i = 0; i < code.len(); i++) begin
            byte ch;
            int  ml, sl;
            ch = code[i];
            if (ch == 8'h2d) ml = rnd ? int'($urandom_range(10, 20)) : 12;
            else             ml = rnd ? int'($urandom_range(1, 6))   : 4;
            sl = rnd ? int'($urandom_range(2, 10)) : 4;
            bus.key_in = 1'b1;
            repeat (ml) @(negedge clk);
            if (i != code.len() - 1) begin
                bus.key_in = 1'b0;
                repeat (sl) @(negedge clk);
            end
        end
    endtask

    task automatic conclude(input string code);
        int c0, v0, e0, idx, n;
        logic [3:0] pat;
        byte ch;
        bus.key_in = 1'b0;
        c0 = cyc;
        v0 = nv;
        e0 = ne;
        last_pulse = -1;
        repeat (WINDOW) @(negedge clk);
        n   = code.len();
        idx = -1;
        pat = '0;
        foreach (morse_tbl[k]) if (morse_tbl[k] == code) idx = k;
        for (int i = 0; i < n && i < 4; i++) begin
            ch = code[i];
            pat[i] = (ch == 8'h2d);
        end
        check_eq({"valid_count ", code}, nv - v0, (idx >= 0) ? 1 : 0);
        check_eq({"error_count ", code}, ne - e0, (idx >= 0) ? 0 : 1);
        check_eq({"latency ", code}, last_pulse - c0, LAT);
        if (n <= 4) begin
            check_eq({"pattern ", code}, int'(bus.pattern), int'(pat));
            check_eq({"length ", code}, int'(bus.length), n);
        end
        if (idx >= 0) check_eq({"letter ", code}, int'(bus.letter), idx);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " letter"},       int'(bus.letter), 0);
        check_eq({tag, " letter_valid"}, int'(bus.letter_valid), 0);
        check_eq({tag, " letter_error"}, int'(bus.letter_error), 0);
        check_eq({tag, " pattern"},      int'(bus.pattern), 0);
        check_eq({tag, " length"},       int'(bus.length), 0);
    endtask

    initial begin
        int v0, e0;
        bus.key_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        play(".-", 1'b0);    conclude(".-");
        play(".", 1'b0);     conclude(".");
        play("....", 1'b0);  conclude("....");
        play(".....", 1'b0); conclude(".....");
        play("---", 1'b0);   conclude("---");

        play(".-", 1'b0);
        bus.key_in = 1'b0;
        repeat (4) @(negedge clk);
        v0 = nv;
        e0 = ne;
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        repeat (WINDOW) @(negedge clk);
        check_eq("mid_reset no_pulse", (nv - v0) + (ne - e0), 0);
        play(".-", 1'b0);    conclude(".-");

        for (int r = 0; r < 20; r++) begin
            string code;
            int n;
            if ($urandom_range(0, 2) != 0) begin
                code = morse_tbl[$urandom_range(0, 7)];
            end else begin
                code = "";
                n = int'($urandom_range(1, 5));
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 1) != 0) code = {code, "-"};
                    else                           code = {code, "."};
                end
            end
            play(code, 1'b1);
            conclude(code);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/morse_code_receiver.md
MORSE_CODE_RECEIVER -- requirements
Module: morse_code_receiver

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 25000000, SHALL set clock cycles per Morse time unit (0.5 s at 50 MHz).
REQ-002 Parameter DASH_MIN_UNITS, default 2, SHALL set the minimum mark length, in units, classified as dash.
REQ-003 Parameter LETTER_GAP_UNITS, default 3, SHALL set the space length, in units, that terminates a letter.
REQ-004 CLOCK_50  in  1 -- sole clock, rising edge.
REQ-005 reset  in  1 -- asynchronous, active-high reset.
REQ-006 key_in  in  1 -- asynchronous Morse line; 1 = mark (light on), 0 = space.
REQ-007 letter  out  3 -- decoded letter code, A=000 through H=111.
REQ-008 letter_valid  out  1 -- one-cycle pulse; letter is valid in that cycle.
REQ-009 letter_error  out  1 -- one-cycle pulse for an unknown or overlong pattern.
REQ-010 pattern  out  4 -- captured symbols; bit0 is the first symbol; 1 = dash, 0 = dot.
REQ-011 length  out  3 -- captured symbol count, 0-4.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; all timing SHALL use the synchronized level (key_s).
REQ-013 The FSM SHALL have states IDLE, MARK, SPACE, ABORT and DECODE.
REQ-014 Unit timer: a tick counter SHALL wrap at TICKS_PER_UNIT-1 and increment a 3-bit unit counter that saturates at 7; both SHALL clear on every key_s edge.
REQ-015 IDLE: on key_s rise, the FSM SHALL clear pattern and length and go to MARK.
REQ-016 MARK: on key_s fall, if units < DASH_MIN_UNITS the symbol SHALL be a dot, else a dash.
REQ-017 In MARK, the symbol SHALL be written to pattern[length], length SHALL increment, and the FSM SHALL go to SPACE.
REQ-018 A mark that falls while length==4 SHALL NOT be stored; the FSM SHALL go to ABORT.
REQ-019 SPACE: a key_s rise before units reaches LETTER_GAP_UNITS SHALL return the FSM to MARK, keeping pattern and length.
REQ-020 SPACE: when units reaches LETTER_GAP_UNITS, the FSM SHALL go to DECODE.
REQ-021 ABORT SHALL ignore marks and wait for a LETTER_GAP_UNITS space, then pulse letter_error for one cycle and go to IDLE.
REQ-022 DECODE (one cycle): a {pattern,length} match SHALL assert letter_valid with letter set; otherwise it SHALL assert letter_error. The FSM then SHALL go to IDLE.
REQ-023 The decode table SHALL be (pattern/length): A 0010/2, B 0001/4, C 0101/4, D 0001/3, E 0000/1, F 0100/4, G 0011/3, H 0000/4.
REQ-024 letter, pattern and length SHALL hold their values until the next IDLE-to-MARK transition.
REQ-025 letter_valid and letter_error SHALL never be asserted in the same cycle.
REQ-026 Latency: the pulse SHALL assert exactly one cycle after the unit counter reaches LETTER_GAP_UNITS.

Reset
REQ-027 On reset, all outputs SHALL be zero and the FSM SHALL be in IDLE.
REQ-028 On reset, the synchronizer and both counters SHALL be zero.
REQ-029 Reset asserted mid-letter SHALL discard the partial letter with no pulse.

Configuration
REQ-030 With MORSE_RX_GLITCH_FILTER_EN defined, a key_s level SHALL be accepted only after 16 consecutive stable cycles; shorter pulses SHALL be ignored.
REQ-031 Without MORSE_RX_GLITCH_FILTER_EN, key_s SHALL be used directly, adding zero filter latency.

Structure
REQ-032 Package morse_pkg SHALL hold the letter codes, the A-H pattern/length constants (shared with the transmitter) and the FSM state typedef.
REQ-033 The tick/unit counter SHALL be sub-module morse_unit_timer, with inputs clear and tick_enable and a saturating units output.

Verification (TICKS_PER_UNIT=4, macro undefined)
REQ-034 The bench SHALL cover: mark 4 cycles, space 4, mark 12, space 12 -> letter_valid, letter=000 (A), pattern=0010, length=2.
REQ-035 The bench SHALL cover: single 4-cycle mark, space 12 -> letter=100 (E), length=1.
REQ-036 The bench SHALL cover: four dots, then 12-cycle space -> letter=111 (H), pattern=0000, length=4.
REQ-037 The bench SHALL cover: five dots -> ABORT; after the 12-cycle gap, one letter_error pulse and no letter_valid.
REQ-038 The bench SHALL cover: dash,dash,dash (pattern 0111, length 3), gap -> letter_error.
REQ-039 The bench SHALL cover: reset asserted after two symbols -> outputs zero, no pulse; the next A then decodes correctly.
